// File: rtl/cpu_pkg.sv
// Shared types for the core's decode/register-transfer path: transfer modes,
// sequencer states and register index type.
package cpu_pkg;

    typedef enum logic {
        MODE_IA = 1'b0,
        MODE_DB = 1'b1
    } xfer_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    typedef logic [3:0] reg_addr_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/lowest_set_bit.sv
// 16-bit priority encoder: index of the lowest set bit plus a valid flag.
// Shared with decode, so it stays purely combinational.
module lowest_set_bit
    import cpu_pkg::*;
(
    input  logic [15:0] vec_i,
    output reg_addr_t   idx_o,
    output logic        valid_o
);

    always_comb begin
        idx_o = '0;
        // Scan downwards so the lowest set bit is the last one to win.
        for (int i = 15; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = reg_addr_t'(i);
            end
        end
        valid_o = |vec_i;
    end

endmodule

// File: rtl/reg_list_sequencer.sv
// LDM/STM/PUSH/POP sequencer: walks a 16-bit register list one memory beat
// at a time, driving the register-file ports and a single-beat memory port.
module reg_list_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        mode,
    input  logic [15:0] reg_list,
    input  logic [31:0] base_addr,
    input  logic [3:0]  rn,
    input  logic        wback,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  rf_read_addr,
    input  logic [31:0] rf_read_data,
    output logic        rf_write_en,
    output logic [3:0]  rf_write_addr,
    output logic [31:0] rf_write_data
);

    seq_state_e  state_q, state_d;
    logic        is_load_q, is_load_d;
    reg_addr_t   rn_q, rn_d;
    logic        wback_q, wback_d;
    logic        rn_in_list_q, rn_in_list_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] final_base_q, final_base_d;

    logic [4:0]  count;
    logic [31:0] span;
    reg_addr_t   cur;
    logic        cur_valid;

    lowest_set_bit u_lsb (
        .vec_i   (remaining_q),
        .idx_o   (cur),
        .valid_o (cur_valid)
    );

    always_comb begin
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + {4'b0000, reg_list[i]};
        end
        span = 32'(count) * 32'(WORD_BYTES);
    end

    always_comb begin
        state_d       = state_q;
        is_load_d     = is_load_q;
        rn_d          = rn_q;
        wback_d       = wback_q;
        rn_in_list_d  = rn_in_list_q;
        remaining_d   = remaining_q;
        addr_d        = addr_q;
        final_base_d  = final_base_q;

        busy          = (state_q != IDLE);
        done          = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        rf_read_addr  = '0;
        rf_write_en   = 1'b0;
        rf_write_addr = '0;
        rf_write_data = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_load_d    = is_load;
                    rn_d         = rn;
                    wback_d      = wback;
                    rn_in_list_d = reg_list[rn];
                    remaining_d  = reg_list;
                    if (xfer_mode_e'(mode) == MODE_DB) begin
                        // Lowest register sits at the lowest address in both modes.
                        addr_d       = base_addr - span;
                        final_base_d = base_addr - span;
                    end else begin
                        addr_d       = base_addr;
                        final_base_d = base_addr + span;
                    end
                    state_d = (reg_list == 16'h0000) ? DONE : XFER;
                end
            end
            XFER: begin
                mem_req      = 1'b1;
                mem_we       = ~is_load_q;
                mem_addr     = addr_q;
                rf_read_addr = cur;
                mem_wdata    = is_load_q ? 32'h0 : rf_read_data;
                if (mem_ready && cur_valid) begin
                    // Gating on rst keeps a reset in this cycle from committing a load.
                    rf_write_en   = is_load_q && !rst;
                    rf_write_addr = is_load_q ? cur : 4'h0;
                    rf_write_data = is_load_q ? mem_rdata : 32'h0;
                    remaining_d   = remaining_q & ~(16'h0001 << cur);
                    addr_d        = addr_q + 32'(WORD_BYTES);
                    if (remaining_d == 16'h0000) begin
                        state_d = (wback_q && !(is_load_q && rn_in_list_q)) ? WB : DONE;
                    end
                end
            end
            WB: begin
                rf_write_en   = !rst;
                rf_write_addr = rn_q;
                rf_write_data = final_base_q;
                state_d       = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            is_load_q    <= 1'b0;
            rn_q         <= '0;
            wback_q      <= 1'b0;
            rn_in_list_q <= 1'b0;
            remaining_q  <= '0;
            addr_q       <= '0;
            final_base_q <= '0;
        end else begin
            state_q      <= state_d;
            is_load_q    <= is_load_d;
            rn_q         <= rn_d;
            wback_q      <= wback_d;
            rn_in_list_q <= rn_in_list_d;
            remaining_q  <= remaining_d;
            addr_q       <= addr_d;
            final_base_q <= final_base_d;
        end
    end

endmodule
